// File: rtl/u409_autoconfig_ctrl.sv
// u409_autoconfig_ctrl
// AUTOCONFIG sequencer for the U409 logical boards (PCI bridge, LIDE/ATA and,
// optionally, the Prometheus Z3 window). Answers CPU cycles in $00E8xxxx,
// serves each board's expansion nibble ROM and latches the assigned bases.
//
// Build option: define PROMETHEUS_EN to include the Prometheus (Z3) board.
// Without it the chain is BRIDGE -> LIDE -> DONE and PRO_BASE is tied to 0.
//
// Bus handshake: a cycle starts when TSn is sampled low with AC_SPACE high,
// CONFIGn_IN low and boards still unconfigured. Exactly one TACK pulse
// answers it two clocks after the start edge, D_OE rides with TACK on reads,
// and TSn seen while a cycle is in flight is dropped (no queueing).
`timescale 1ns/1ps

module u409_autoconfig_ctrl #(
   parameter logic [15:0] MFG_ID      = 16'h0A1C,
   parameter logic [7:0]  PROD_BRIDGE = 8'h01,
   parameter logic [7:0]  PROD_LIDE   = 8'h02,
   parameter logic [7:0]  PROD_PRO    = 8'h03
) (
   input  logic        CLK40,
   input  logic        RESET,
   input  logic        AC_SPACE,
   input  logic        TSn,
   input  logic        RnW,
   input  logic [7:1]  A,
   input  logic        CONFIGn_IN,
   input  logic [31:24] D_IN,
   output logic [31:28] D_OUT,
   output logic        D_OE,
   output logic        TACK,
   output logic [7:0]  BRIDGE_BASE,
   output logic [7:1]  LIDE_BASE,
   output logic [3:0]  PRO_BASE,
   output logic        CONFIGURED,
   output logic        CONFIGn_OUT,
   output logic [1:0]  DBG_STATE,
   output logic [1:0]  DBG_DEV
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ACK = 2'd2} state_t;
   typedef enum logic [1:0] {DEV_BRIDGE = 2'd0, DEV_LIDE = 2'd1, DEV_PRO = 2'd2, DEV_DONE = 2'd3} dev_t;

   // Register offsets (A[7:1]) of the writable AUTOCONFIG registers.
   localparam logic [7:1] OFF_Z3_BASE = 7'h22; // $44
   localparam logic [7:1] OFF_BASE_HI = 7'h24; // $48
   localparam logic [7:1] OFF_BASE_LO = 7'h25; // $4A
   localparam logic [7:1] OFF_SHUTUP  = 7'h26; // $4C

   // Input sample stage: every bus input is registered before use.
   logic       ts_q, ts_d;
   logic       ac_q, ac_d;
   logic       cfgn_q, cfgn_d;
   logic       rnw_in_q, rnw_in_d;
   logic [7:1] a_in_q, a_in_d;
   logic [3:0] din_in_q, din_in_d;

   // Cycle latches, FSM and configuration state.
   state_t     state_q, state_d;
   dev_t       dev_q, dev_d;
   logic       cyc_rnw_q, cyc_rnw_d;
   logic [7:1] cyc_a_q, cyc_a_d;
   logic [3:0] cyc_din_q, cyc_din_d;
   logic [3:0] pend_q, pend_d;
   logic [7:0] bridge_base_q, bridge_base_d;
   logic [6:0] lide_base_q, lide_base_d;
   logic [3:0] pro_base_q, pro_base_d;
   logic       tack_q, tack_d;
   logic       d_oe_q, d_oe_d;
   logic [3:0] d_out_q, d_out_d;
   logic       configured_q, configured_d;
   logic       confign_out_q, confign_out_d;

   logic [3:0] rom_nib;
   logic       unused_din;

   // Low data byte bits are not part of any AUTOCONFIG register.
   assign unused_din = ^D_IN[27:24];

   // Board that follows the given one in the chain.
   function automatic dev_t next_dev(input dev_t dev);
      dev_t nxt;
      case (dev)
         DEV_BRIDGE: nxt = DEV_LIDE;
`ifdef PROMETHEUS_EN
         DEV_LIDE:   nxt = DEV_PRO;
`else
         DEV_LIDE:   nxt = DEV_DONE;
`endif
         default:    nxt = DEV_DONE;
      endcase
      return nxt;
   endfunction

   // ROM byte of the active board; byte index is the register offset / 4.
   function automatic logic [7:0] rom_byte(input dev_t dev, input logic [5:0] idx);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         6'h00: begin
            case (dev)
               DEV_BRIDGE: b = 8'hC1;
               DEV_LIDE:   b = 8'hD2;
`ifdef PROMETHEUS_EN
               DEV_PRO:    b = 8'h84;
`endif
               default:    b = 8'h00;
            endcase
         end
         6'h01: begin
            case (dev)
               DEV_BRIDGE: b = PROD_BRIDGE;
               DEV_LIDE:   b = PROD_LIDE;
`ifdef PROMETHEUS_EN
               DEV_PRO:    b = PROD_PRO;
`endif
               default:    b = 8'h00;
            endcase
         end
`ifdef PROMETHEUS_EN
         6'h02: b = (dev == DEV_PRO) ? 8'h20 : 8'h00;
`endif
         6'h04: b = MFG_ID[15:8];
         6'h05: b = MFG_ID[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

`ifndef PROMETHEUS_EN
   logic [7:0] unused_prod;
   assign unused_prod = PROD_PRO;
`endif

   // Nibble lookup: A[1] picks the low nibble; only er_Type ($00/$02) reads true.
   always_comb begin
      logic [7:0] b;
      logic [3:0] n;
      b = rom_byte(dev_q, cyc_a_q[7:2]);
      n = cyc_a_q[1] ? b[3:0] : b[7:4];
      rom_nib = (cyc_a_q[7:2] == 6'h00) ? n : ~n;
   end

   // Next-state, cycle handling and write application.
   always_comb begin
      ts_d          = ~TSn;
      ac_d          = AC_SPACE;
      cfgn_d        = CONFIGn_IN;
      rnw_in_d      = RnW;
      a_in_d        = A;
      din_in_d      = D_IN[31:28];
      state_d       = state_q;
      dev_d         = dev_q;
      cyc_rnw_d     = cyc_rnw_q;
      cyc_a_d       = cyc_a_q;
      cyc_din_d     = cyc_din_q;
      pend_d        = pend_q;
      bridge_base_d = bridge_base_q;
      lide_base_d   = lide_base_q;
      pro_base_d    = pro_base_q;
      tack_d        = 1'b0;
      d_oe_d        = 1'b0;
      d_out_d       = 4'h0;

      case (state_q)
         ST_IDLE: begin
            if (ts_q && ac_q && !cfgn_q && (dev_q != DEV_DONE)) begin
               cyc_rnw_d = rnw_in_q;
               cyc_a_d   = a_in_q;
               cyc_din_d = din_in_q;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            state_d = ST_ACK;
            tack_d  = 1'b1;
            d_oe_d  = cyc_rnw_q;
            if (cyc_rnw_q) begin
               d_out_d = rom_nib;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            if (!cyc_rnw_q) begin
               case (cyc_a_q)
                  OFF_BASE_LO: begin
                     if ((dev_q == DEV_BRIDGE) || (dev_q == DEV_LIDE)) begin
                        pend_d = cyc_din_q;
                     end
                  end
                  OFF_BASE_HI: begin
                     if (dev_q == DEV_BRIDGE) begin
                        bridge_base_d = {cyc_din_q, pend_q};
                        dev_d         = next_dev(dev_q);
                     end else if (dev_q == DEV_LIDE) begin
                        lide_base_d = {cyc_din_q, pend_q[3:1]};
                        dev_d       = next_dev(dev_q);
                     end
                  end
`ifdef PROMETHEUS_EN
                  OFF_Z3_BASE: begin
                     if (dev_q == DEV_PRO) begin
                        pro_base_d = cyc_din_q;
                        dev_d      = next_dev(dev_q);
                     end
                  end
`endif
                  OFF_SHUTUP: dev_d = next_dev(dev_q);
                  default: ;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase

      configured_d  = (dev_d == DEV_DONE);
      confign_out_d = (dev_d != DEV_DONE);
   end

   // State and output registers; synchronous reset aborts any cycle in flight.
   always_ff @(posedge CLK40) begin
      if (RESET) begin
         ts_q          <= 1'b0;
         ac_q          <= 1'b0;
         cfgn_q        <= 1'b1;
         rnw_in_q      <= 1'b1;
         a_in_q        <= '0;
         din_in_q      <= '0;
         state_q       <= ST_IDLE;
         dev_q         <= DEV_BRIDGE;
         cyc_rnw_q     <= 1'b1;
         cyc_a_q       <= '0;
         cyc_din_q     <= '0;
         pend_q        <= '0;
         bridge_base_q <= '0;
         lide_base_q   <= '0;
         pro_base_q    <= '0;
         tack_q        <= 1'b0;
         d_oe_q        <= 1'b0;
         d_out_q       <= '0;
         configured_q  <= 1'b0;
         confign_out_q <= 1'b1;
      end else begin
         ts_q          <= ts_d;
         ac_q          <= ac_d;
         cfgn_q        <= cfgn_d;
         rnw_in_q      <= rnw_in_d;
         a_in_q        <= a_in_d;
         din_in_q      <= din_in_d;
         state_q       <= state_d;
         dev_q         <= dev_d;
         cyc_rnw_q     <= cyc_rnw_d;
         cyc_a_q       <= cyc_a_d;
         cyc_din_q     <= cyc_din_d;
         pend_q        <= pend_d;
         bridge_base_q <= bridge_base_d;
         lide_base_q   <= lide_base_d;
         pro_base_q    <= pro_base_d;
         tack_q        <= tack_d;
         d_oe_q        <= d_oe_d;
         d_out_q       <= d_out_d;
         configured_q  <= configured_d;
         confign_out_q <= confign_out_d;
      end
   end

   assign TACK        = tack_q;
   assign D_OE        = d_oe_q;
   assign D_OUT       = d_out_q;
   assign BRIDGE_BASE = bridge_base_q;
   assign LIDE_BASE   = lide_base_q;
`ifdef PROMETHEUS_EN
   assign PRO_BASE    = pro_base_q;
`else
   assign PRO_BASE    = 4'h0;
   logic [3:0] unused_pro_base;
   assign unused_pro_base = pro_base_q;
`endif
   assign CONFIGURED  = configured_q;
   assign CONFIGn_OUT = confign_out_q;
   assign DBG_STATE   = state_q;
   assign DBG_DEV     = dev_q;

endmodule
